dma_burst_sched: RTL

DMA_BURST_SCHED -- requirements
Module: dma_burst_sched

---
 rtl/dma_sched_pkg.sv | 21 ++
 rtl/dma_rr_pick.sv | 37 +++
 rtl/dma_burst_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dma_sched_pkg.sv
// dma_sched_pkg: shared types and constants for the DMA burst scheduler.
//   state_e     - scheduler FSM states (idle / command / data)
//   CH_NUM_DEF  - default channel count
//   calc_idw()  - channel index width, never less than 1 bit
package dma_sched_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCmd  = 2'd1,
    StData = 2'd2
  } state_e;

  localparam int unsigned CH_NUM_DEF = 4;

  function automatic int unsigned calc_idw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IDW_DEF = calc_idw(CH_NUM_DEF);

endpackage

// File: rtl/dma_rr_pick.sv
// dma_rr_pick: combinational rotating-priority picker.
//   reqs  in  CH_NUM  request vector
//   ptr   in  IDW     highest-priority channel for this pick
//   grant out CH_NUM  one-hot grant (all zero when no request)
//   idx   out IDW     index of the granted channel
// CH_NUM must be a power of two so the candidate index wraps naturally.
module dma_rr_pick
  import dma_sched_pkg::*;
#(
  parameter int unsigned CH_NUM = CH_NUM_DEF,
  localparam int unsigned IDW = calc_idw(CH_NUM)
) (
  input  logic [CH_NUM-1:0] reqs,
  input  logic [IDW-1:0]    ptr,
  output logic [CH_NUM-1:0] grant,
  output logic [IDW-1:0]    idx
);

  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      cand = ptr + IDW'(i);
      if (!found && reqs[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/dma_burst_sched.sv
// dma_burst_sched: round-robin scheduler issuing one read burst at a time
// for CH_NUM DMA channels and routing the returned beats to the owner.
//   clk, rstn                 clock (rising edge), async active-low reset
//   ch_req/ch_addr/ch_len     per-channel burst requests (len = beats-1)
//   ch_ack                    one-cycle pulse when a channel's command is taken
//   ar_valid/ar_ready/ar_*    read command channel (address, len, channel id)
//   r_valid/r_ready/r_last/r_data  read data channel
//   ch_rvalid/ch_rdata/ch_rlast    beats routed to the granted channel
//   busy                      scheduler not idle
//   err                       one-cycle pulse on length mismatch or timeout
// Optional build macro DMA_SCHED_TIMEOUT_EN: abandon a burst after TO_CYC
// consecutive data-phase cycles without a beat.
module dma_burst_sched
  import dma_sched_pkg::*;
#(
  parameter int unsigned CH_NUM = CH_NUM_DEF,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TO_CYC = 255,
  localparam int unsigned IDW = calc_idw(CH_NUM)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [CH_NUM-1:0]        ch_req,
  input  logic [CH_NUM*ADDR_W-1:0] ch_addr,
  input  logic [CH_NUM*LEN_W-1:0]  ch_len,
  output logic [CH_NUM-1:0]        ch_ack,
  output logic                     ar_valid,
  input  logic                     ar_ready,
  output logic [ADDR_W-1:0]        ar_addr,
  output logic [LEN_W-1:0]         ar_len,
  output logic [IDW-1:0]           ar_id,
  input  logic                     r_valid,
  output logic                     r_ready,
  input  logic                     r_last,
  input  logic [DATA_W-1:0]        r_data,
  output logic [CH_NUM-1:0]        ch_rvalid,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     ch_rlast,
  output logic                     busy,
  output logic                     err
);

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      g_q, g_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;

  logic [CH_NUM-1:0]   pick_grant;
  logic [IDW-1:0]      pick_idx;
  logic [CH_NUM-1:0]   g_oh;
  logic                ar_hs;
  logic                beat;
  logic                to_hit;
  logic                burst_end;

  dma_rr_pick #(
    .CH_NUM(CH_NUM)
  ) u_pick (
    .reqs  (ch_req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign ar_hs     = (state_q == StCmd) && ar_ready;
  assign beat      = (state_q == StData) && r_valid;
  assign burst_end = (beat && r_last) || to_hit;

`ifdef DMA_SCHED_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TO_CYC + 1);
  logic [ToW-1:0] to_q, to_d;

  // Counts consecutive beat-less data cycles; any beat or leaving DATA clears it.
  always_comb begin
    to_d = '0;
    if ((state_q == StData) && !r_valid) to_d = to_q + 1'b1;
  end

  // Fires on the TO_CYC-th idle data cycle.
  assign to_hit = (state_q == StData) && !r_valid && (to_q == ToW'(TO_CYC - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) to_q <= '0;
    else       to_q <= to_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      g_q     <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (|pick_grant) state_d = StCmd;
      StCmd:   if (ar_ready) state_d = StData;
      StData:  if (burst_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values.
  always_comb begin
    ptr_d  = ptr_q;
    g_d    = g_q;
    addr_d = addr_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    if ((state_q == StIdle) && (|pick_grant)) begin
      g_d    = pick_idx;
      addr_d = ch_addr[pick_idx*ADDR_W +: ADDR_W];
      len_d  = ch_len[pick_idx*LEN_W +: LEN_W];
    end
    if (ar_hs) cnt_d = len_q;
    // Saturate at zero so an over-long burst does not wrap the counter.
    if (beat && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
    if (burst_end) ptr_d = g_q + 1'b1;
  end

  always_comb begin
    g_oh      = '0;
    g_oh[g_q] = 1'b1;
  end

  // Outputs.
  always_comb begin
    ar_valid  = (state_q == StCmd);
    ar_addr   = addr_q;
    ar_len    = len_q;
    ar_id     = g_q;
    ch_ack    = ar_hs ? g_oh : '0;
    r_ready   = (state_q == StData);
    ch_rvalid = beat ? g_oh : '0;
    ch_rdata  = r_data;
    ch_rlast  = beat && r_last;
    busy      = (state_q != StIdle);
    // Early r_last, or a beat past the expected last one without r_last.
    err       = (beat && (r_last != (cnt_q == '0))) || to_hit;
  end

endmodule
